// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: bus widths, op bit indices and divider state encoding shared by exe_stage
package exe_stage_pkg;
  localparam int ID_TO_EXE_LEN  = 163;
  localparam int EXE_TO_MEM_LEN = 80;
  localparam int EXE_RF_LEN     = 38;
  localparam int DIV_W          = 32;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;
  localparam int MD_MUL   = 0;
  localparam int MD_MULH  = 1;
  localparam int MD_MULHU = 2;
  localparam int MD_DIV   = 3;
  localparam int MD_MOD   = 4;
  localparam int MD_DIVU  = 5;
  localparam int MD_MODU  = 6;
  localparam int SL_LDB   = 0;
  localparam int SL_LDH   = 1;
  localparam int SL_LDW   = 2;
  localparam int SL_STB   = 3;
  localparam int SL_STH   = 4;
  localparam int SL_STW   = 5;
  localparam int SL_LDBU  = 6;
  localparam int SL_LDHU  = 7;
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;
endpackage

// File: rtl/exe_stage_div_iter.sv
// exe_stage_div_iter: restoring radix-2 divider, done 33 cycles after start (EXE_DIV_ZERO_FAST_EN: divide by zero done after 1)
module exe_stage_div_iter
  import exe_stage_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_op,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder
);
  div_state_t state, state_nx;
  logic [4:0] cnt;
  logic [DIV_W-1:0] quot, rem, dvs, a_abs, b_abs;
  logic [DIV_W:0] tmp;
  logic a_neg, b_neg, q_neg, r_neg, dv_zero, ge, zero_fast;
`ifdef EXE_DIV_ZERO_FAST_EN
  assign zero_fast = divisor == '0;
`else
  assign zero_fast = 1'b0;
`endif
  assign a_neg = signed_op & dividend[DIV_W-1];
  assign b_neg = signed_op & divisor[DIV_W-1];
  assign a_abs = a_neg ? -dividend : dividend;
  assign b_abs = b_neg ? -divisor : divisor;
  assign tmp = {rem, quot[DIV_W-1]};
  assign ge = tmp >= {1'b0, dvs};
  assign busy = state != DIV_IDLE;
  assign done = state == DIV_DONE;
  assign quotient = dv_zero ? '1 : q_neg ? -quot : quot;
  assign remainder = r_neg ? -rem : rem;
  // next state: IDLE -> RUN for 32 steps -> DONE for one cycle -> IDLE
  always_comb begin
    state_nx = state == DIV_IDLE ? (start ? (zero_fast ? DIV_DONE : DIV_RUN) : DIV_IDLE) :
               state == DIV_RUN  ? (cnt == 5'd31 ? DIV_DONE : DIV_RUN) : DIV_IDLE;
  end
  // state register, operand capture and one shift-subtract step per RUN cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= DIV_IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == DIV_IDLE && start) begin
        quot <= a_abs;
        rem <= zero_fast ? a_abs : '0;
        dvs <= b_abs;
        cnt <= '0;
        q_neg <= a_neg ^ b_neg;
        r_neg <= a_neg;
        dv_zero <= divisor == '0;
      end else if (state == DIV_RUN) begin
        cnt <= cnt + 5'd1;
        rem <= ge ? tmp[DIV_W-1:0] - dvs : tmp[DIV_W-1:0];
        quot <= {quot[DIV_W-2:0], ge};
      end
    end
  end
endmodule

// File: rtl/exe_stage.sv
// exe_stage: LoongArch32 execute stage (ALU, multiply, iterative divide, data-SRAM request); EXE_DIV_ZERO_FAST_EN shortens divide-by-zero
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      id_to_exe_valid,
  input  logic [ID_TO_EXE_LEN-1:0]  id_to_exe_bus,
  output logic                      exe_allowin,
  input  logic                      mem_allowin,
  output logic                      exe_to_mem_valid,
  output logic [EXE_TO_MEM_LEN-1:0] exe_to_mem_bus,
  output logic [EXE_RF_LEN-1:0]     exe_rf_bus,
  output logic                      data_sram_en,
  output logic [3:0]                data_sram_we,
  output logic [31:0]               data_sram_addr,
  output logic [31:0]               data_sram_wdata
);
  logic [ID_TO_EXE_LEN-1:0] bus_r;
  logic [31:0] pc, rkd_value, src1, src2;
  logic [31:0] add_res, sub_res, sra_res, alu_res, mul_res, div_q, div_r, div_res, result;
  logic [11:0] alu_op;
  logic [7:0] sl_op;
  logic [6:0] md_op;
  logic [4:0] dest, load_op;
  logic [3:0] st_we;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] prod;
  logic gr_we, mem_en, rfrom_mem, exe_valid, exe_ready_go, leave, mem_access;
  logic is_mul, is_div, div_started, div_held, div_start, div_busy, div_done;
  assign {pc, gr_we, dest, rkd_value, mem_en, alu_op, src1, src2, sl_op, rfrom_mem, md_op} = bus_r;
  assign add_res = src1 + src2;
  assign sub_res = src1 - src2;
  assign sra_res = $signed(src1) >>> src2[4:0];
  assign alu_res = ({32{alu_op[ALU_ADD]}}  & add_res)
                 | ({32{alu_op[ALU_SUB]}}  & sub_res)
                 | ({32{alu_op[ALU_SLT]}}  & {31'd0, $signed(src1) < $signed(src2)})
                 | ({32{alu_op[ALU_SLTU]}} & {31'd0, src1 < src2})
                 | ({32{alu_op[ALU_AND]}}  & (src1 & src2))
                 | ({32{alu_op[ALU_NOR]}}  & ~(src1 | src2))
                 | ({32{alu_op[ALU_OR]}}   & (src1 | src2))
                 | ({32{alu_op[ALU_XOR]}}  & (src1 ^ src2))
                 | ({32{alu_op[ALU_SLL]}}  & (src1 << src2[4:0]))
                 | ({32{alu_op[ALU_SRL]}}  & (src1 >> src2[4:0]))
                 | ({32{alu_op[ALU_SRA]}}  & sra_res)
                 | ({32{alu_op[ALU_LUI]}}  & src2);
  assign mul_a = {md_op[MD_MULH] & src1[31], src1};
  assign mul_b = {md_op[MD_MULH] & src2[31], src2};
  assign prod = mul_a * mul_b;
  assign mul_res = md_op[MD_MUL] ? prod[31:0] : prod[63:32];
  assign is_mul = |md_op[MD_MULHU:MD_MUL];
  assign is_div = |md_op[MD_MODU:MD_DIV];
  assign div_res = md_op[MD_DIV] | md_op[MD_DIVU] ? div_q : div_r;
  assign result = is_mul ? mul_res : is_div ? div_res : alu_res;
  assign div_start = exe_valid & is_div & ~div_started & ~div_busy;
  assign exe_ready_go = ~is_div | div_done | div_held;
  assign exe_allowin = ~exe_valid | (exe_ready_go & mem_allowin);
  assign exe_to_mem_valid = exe_valid & exe_ready_go;
  assign leave = exe_to_mem_valid & mem_allowin;
  exe_stage_div_iter u_div (
    .clk(clk),
    .resetn(resetn),
    .start(div_start),
    .signed_op(md_op[MD_DIV] | md_op[MD_MOD]),
    .dividend(src1),
    .divisor(src2),
    .busy(div_busy),
    .done(div_done),
    .quotient(div_q),
    .remainder(div_r)
  );
  assign mem_access = mem_en | (|sl_op);
  assign st_we = sl_op[SL_STW] ? 4'b1111 :
                 sl_op[SL_STH] ? (add_res[1] ? 4'b1100 : 4'b0011) :
                 sl_op[SL_STB] ? 4'b0001 << add_res[1:0] : 4'b0000;
  assign data_sram_en = exe_valid & mem_access & mem_allowin;
  assign data_sram_we = exe_valid ? st_we : 4'b0000;
  assign data_sram_addr = add_res;
  assign data_sram_wdata = sl_op[SL_STH] ? {2{rkd_value[15:0]}} : sl_op[SL_STB] ? {4{rkd_value[7:0]}} : rkd_value;
  assign load_op = {sl_op[SL_LDB], sl_op[SL_LDH], sl_op[SL_LDW], sl_op[SL_LDBU], sl_op[SL_LDHU]};
  assign exe_to_mem_bus = {pc, gr_we, dest, result, load_op, rfrom_mem, add_res[1:0], 2'b00};
  assign exe_rf_bus = {exe_valid & gr_we ? dest : 5'd0, rfrom_mem, result};
  // stage valid flag and instruction register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      exe_valid <= 1'b0;
      bus_r <= '0;
    end else begin
      if (exe_allowin) exe_valid <= id_to_exe_valid;
      if (id_to_exe_valid & exe_allowin) bus_r <= id_to_exe_bus;
    end
  end
  // one divider start per instruction; hold its result until the instruction leaves
  always_ff @(posedge clk) begin
    if (!resetn || leave) begin
      div_started <= 1'b0;
      div_held <= 1'b0;
    end else begin
      if (div_start) div_started <= 1'b1;
      if (div_done) div_held <= 1'b1;
    end
  end
endmodule
